// File: rtl/alu_multicycle.sv
// alu_multicycle: RV32I/RV64I integer + branch-compare execute unit with an
// iterative one-bit-per-cycle M-extension multiply/divide datapath.
// Valid/ready handshake on both the operand side and the result side.
module alu_multicycle #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    localparam logic [6:0]     OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]     OPC_OP     = 7'b0110011;
    localparam logic [6:0]     OPC_BRANCH = 7'b1100011;
    localparam logic [SHW-1:0] LAST_ITER  = SHW'(XLEN - 1);

    state_t              state_reg, state_next;
    logic [2*XLEN-1:0]   acc_reg, acc_next;    // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]     oper_reg, oper_next;  // multiplicand or divisor magnitude
    logic [SHW-1:0]      cnt_reg, cnt_next;
    logic                neg_reg, neg_next;    // negate the final result
    logic                hi_reg, hi_next;      // mul: high half wanted; div: remainder wanted
    logic [XLEN-1:0]     out_reg, out_next;

    // Decode straight from the offered word; it is only consumed on accept.
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [SHW-1:0]  shamt_i, shamt_r;
    logic            is_m_op, is_div_op, div_by_zero, div_overflow, div_special;
    logic            accept;
    logic            unused_fields;

    assign opcode        = instruction[6:0];
    assign funct3        = instruction[14:12];
    assign imm           = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    assign shamt_i       = instruction[20 +: SHW];
    assign shamt_r       = op_b[SHW-1:0];
    assign is_m_op       = (opcode == OPC_OP) && (instruction[31:25] == 7'b0000001);
    assign is_div_op     = is_m_op && funct3[2];
    assign div_by_zero   = (op_b == '0);
    assign div_overflow  = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign div_special   = div_by_zero || div_overflow;
    assign unused_fields = ^{instruction[19:15], instruction[11:7]};

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == MUL) || (state_reg == DIV);
    assign out       = out_reg;

    // Single-cycle result for base ops and branch compares; unknown encodings give 0.
    logic [XLEN-1:0] base_result;
    always_comb begin
        base_result = '0;
        case (opcode)
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: base_result = op_a + imm;
                    3'b001: base_result = op_a << shamt_i;
                    3'b010: base_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(imm)};
                    3'b011: base_result = {{(XLEN-1){1'b0}}, op_a < imm};
                    3'b100: base_result = op_a ^ imm;
                    3'b101: base_result = instruction[30] ? $unsigned($signed(op_a) >>> shamt_i)
                                                          : (op_a >> shamt_i);
                    3'b110: base_result = op_a | imm;
                    default: base_result = op_a & imm;
                endcase
            end
            OPC_OP: begin
                case (funct3)
                    3'b000: base_result = instruction[30] ? (op_a - op_b) : (op_a + op_b);
                    3'b001: base_result = op_a << shamt_r;
                    3'b010: base_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    3'b011: base_result = {{(XLEN-1){1'b0}}, op_a < op_b};
                    3'b100: base_result = op_a ^ op_b;
                    3'b101: base_result = instruction[30] ? $unsigned($signed(op_a) >>> shamt_r)
                                                          : (op_a >> shamt_r);
                    3'b110: base_result = op_a | op_b;
                    default: base_result = op_a & op_b;
                endcase
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000: base_result = {{(XLEN-1){1'b0}}, op_a == op_b};
                    3'b001: base_result = {{(XLEN-1){1'b0}}, op_a != op_b};
                    3'b100: base_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    3'b101: base_result = {{(XLEN-1){1'b0}}, $signed(op_a) >= $signed(op_b)};
                    3'b110: base_result = {{(XLEN-1){1'b0}}, op_a < op_b};
                    3'b111: base_result = {{(XLEN-1){1'b0}}, op_a >= op_b};
                    default: base_result = '0;
                endcase
            end
            default: base_result = '0;
        endcase
    end

    // Operand magnitudes, result sign and starting accumulator for an M-op.
    logic            a_signed, b_signed, a_neg, b_neg, init_neg, init_hi;
    logic [XLEN-1:0] a_mag, b_mag, init_oper, special_result;
    logic [2*XLEN-1:0] init_acc;
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                 a_signed = 1'b1;
            default:                ;
        endcase
        a_neg     = a_signed && op_a[XLEN-1];
        b_neg     = b_signed && op_b[XLEN-1];
        a_mag     = a_neg ? -op_a : op_a;
        b_mag     = b_neg ? -op_b : op_b;
        init_neg  = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        init_hi   = funct3[2] ? funct3[1] : (funct3 != 3'b000);
        init_acc  = funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
        init_oper = funct3[2] ? b_mag : a_mag;
        if (div_by_zero) special_result = funct3[1] ? op_a : '1;
        else             special_result = funct3[1] ? '0 : op_a;
    end

    // One shift-add or restore-subtract step; the last step also folds in the sign fix-up.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   mul_addend, div_pick, final_result;
    logic [2*XLEN-1:0] mul_step, div_step, mul_full, step;
    always_comb begin
        mul_addend = acc_reg[0] ? oper_reg : '0;
        mul_sum    = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        mul_step   = {mul_sum, acc_reg[XLEN-1:1]};
        div_shift  = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        div_diff   = div_shift - {1'b0, oper_reg};
        if (div_diff[XLEN]) div_step = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
        else                div_step = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        mul_full = neg_reg ? -mul_step : mul_step;
        div_pick = hi_reg ? div_step[2*XLEN-1:XLEN] : div_step[XLEN-1:0];
        if (state_reg == DIV) begin
            step         = div_step;
            final_result = neg_reg ? -div_pick : div_pick;
        end else begin
            step         = mul_step;
            final_result = hi_reg ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
        end
    end

    // Next-state and datapath-load logic; accepting in DONE also delivers the held result.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        oper_next  = oper_reg;
        cnt_next   = cnt_reg;
        neg_next   = neg_reg;
        hi_next    = hi_reg;
        out_next   = out_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    if (is_m_op && !(is_div_op && div_special)) begin
                        state_next = is_div_op ? DIV : MUL;
                        acc_next   = init_acc;
                        oper_next  = init_oper;
                        neg_next   = init_neg;
                        hi_next    = init_hi;
                        cnt_next   = '0;
                    end else begin
                        state_next = DONE;
                        out_next   = is_m_op ? special_result : base_result;
                    end
                end else if ((state_reg == DONE) && out_ready) begin
                    state_next = IDLE;
                end
            end
            MUL, DIV: begin
                acc_next = step;
                cnt_next = cnt_reg + SHW'(1);
                if (cnt_reg == LAST_ITER) begin
                    out_next   = final_result;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            oper_reg  <= '0;
            cnt_reg   <= '0;
            neg_reg   <= 1'b0;
            hi_reg    <= 1'b0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            oper_reg  <= oper_next;
            cnt_reg   <= cnt_next;
            neg_reg   <= neg_next;
            hi_reg    <= hi_next;
            out_reg   <= out_next;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: table vectors, randomized ops against a wide-arithmetic
// reference model, streaming/backpressure/reset sequences, and XLEN=64 checks.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
    logic [31:0] instruction = '0, op_a = '0, op_b = '0, out;
    logic        v64 = 1'b0, irdy64, ov64, ordy64 = 1'b1, busy64;
    logic [31:0] ins64 = '0;
    logic [63:0] a64 = '0, b64 = '0, out64;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.XLEN(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .busy(busy)
    );

    alu_multicycle #(.XLEN(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(v64), .in_ready(irdy64),
        .instruction(ins64), .op_a(a64), .op_b(b64), .out_valid(ov64),
        .out_ready(ordy64), .out(out64), .busy(busy64)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction

    // Reference: ISA semantics computed with plain (wide) arithmetic.
    function automatic logic [31:0] ref32(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [2:0]         f3;
        logic [31:0]        imm;
        logic signed [31:0] sa, sb, simm;
        logic signed [63:0] p;
        logic [63:0]        u;
        f3 = ins[14:12];
        imm = {{20{ins[31]}}, ins[31:20]};
        sa = a; sb = b; simm = imm;
        if (ins[6:0] == 7'b0010011) begin
            case (f3)
                3'd0: return a + imm;
                3'd1: return a << ins[24:20];
                3'd2: return {31'd0, sa < simm};
                3'd3: return {31'd0, a < imm};
                3'd4: return a ^ imm;
                3'd5: begin
                    if (ins[30]) return sa >>> ins[24:20];
                    return a >> ins[24:20];
                end
                3'd6: return a | imm;
                default: return a & imm;
            endcase
        end else if (ins[6:0] == 7'b0110011 && ins[31:25] == 7'b0000001) begin
            case (f3)
                3'd0: return a * b;
                3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
                3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
                3'd3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
                3'd4: begin
                    if (b == 0) return 32'hFFFF_FFFF;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                    return sa / sb;
                end
                3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
                3'd6: begin
                    if (b == 0) return a;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                    return sa % sb;
                end
                default: begin if (b == 0) return a; return a % b; end
            endcase
        end else if (ins[6:0] == 7'b0110011) begin
            case (f3)
                3'd0: begin if (ins[30]) return a - b; return a + b; end
                3'd1: return a << b[4:0];
                3'd2: return {31'd0, sa < sb};
                3'd3: return {31'd0, a < b};
                3'd4: return a ^ b;
                3'd5: begin if (ins[30]) return sa >>> b[4:0]; return a >> b[4:0]; end
                3'd6: return a | b;
                default: return a & b;
            endcase
        end else if (ins[6:0] == 7'b1100011) begin
            case (f3)
                3'd0: return {31'd0, a == b};
                3'd1: return {31'd0, a != b};
                3'd4: return {31'd0, sa < sb};
                3'd5: return {31'd0, sa >= sb};
                3'd6: return {31'd0, a < b};
                3'd7: return {31'd0, a >= b};
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    // Cycles from accept to result: XLEN+1 for iterated mul/div, else 1.
    function automatic int ref_lat32(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic special;
        if (!(ins[6:0] == 7'b0110011 && ins[31:25] == 7'b0000001)) return 1;
        special = ins[14] && (b == 0 || (!ins[12] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return special ? 1 : 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 9);
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string name);
        int k;
        int lat;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        in_valid = 1'b1; instruction = ins; op_a = a; op_b = b; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; instruction = $urandom; op_a = $urandom; op_b = $urandom;
        check({name, " busy"}, busy, exp_lat > 1);
        lat = 1;
        while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
        check({name, " out"}, out, exp);
        check({name, " latency"}, lat, exp_lat);
        $display("[TB] %s ins=%h a=%h b=%h out=%h lat=%0d", name, ins, a, b, out, lat);
    endtask

    task automatic do_op64(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int exp_lat, input string name);
        int k;
        int lat;
        @(negedge clk);
        k = 0;
        while (!irdy64 && k < 50) begin @(negedge clk); k++; end
        v64 = 1'b1; ins64 = ins; a64 = a; b64 = b; ordy64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        lat = 1;
        while (!ov64 && lat < 300) begin @(negedge clk); lat++; end
        check({name, " out"}, out64, exp);
        check({name, " latency"}, lat, exp_lat);
        $display("[TB] %s ins=%h a=%h b=%h out=%h lat=%0d", name, ins, a, b, out64, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] sums[4];
        logic [31:0] r, ins, a, b;
        int          stale;

        vecs.push_back('{enc_i(12'hFFD, 3'd0), 32'd5, 32'd0, 32'd2, 1});
        vecs.push_back('{enc_i({7'h20, 5'd4}, 3'd5), 32'h8000_0000, 32'd0, 32'hF800_0000, 1});
        vecs.push_back('{enc_i(12'd31, 3'd1), 32'd1, 32'd0, 32'h8000_0000, 1});
        vecs.push_back('{enc_r(7'd1, 3'd1), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33});
        vecs.push_back('{enc_r(7'd1, 3'd3), 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 33});
        vecs.push_back('{enc_r(7'd1, 3'd0), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33});
        vecs.push_back('{enc_r(7'd1, 3'd2), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
        vecs.push_back('{enc_r(7'd1, 3'd4), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33});
        vecs.push_back('{enc_r(7'd1, 3'd6), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33});
        vecs.push_back('{enc_r(7'd1, 3'd5), 32'd100, 32'd7, 32'd14, 33});
        vecs.push_back('{enc_r(7'd1, 3'd7), 32'd100, 32'd7, 32'd2, 33});
        vecs.push_back('{enc_r(7'd1, 3'd5), 32'd1234, 32'd0, 32'hFFFF_FFFF, 1});
        vecs.push_back('{enc_r(7'd1, 3'd7), 32'd77, 32'd0, 32'd77, 1});
        vecs.push_back('{enc_r(7'd1, 3'd4), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{enc_r(7'd1, 3'd6), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1});
        vecs.push_back('{enc_r(7'h20, 3'd0), 32'd3, 32'd5, 32'hFFFF_FFFE, 1});
        vecs.push_back('{enc_r(7'd0, 3'd3), 32'd1, 32'hFFFF_FFFF, 32'd1, 1});
        vecs.push_back('{enc_r(7'd0, 3'd2), 32'd1, 32'hFFFF_FFFF, 32'd0, 1});
        vecs.push_back('{enc_b(3'd5), 32'hFFFF_FFFF, 32'd1, 32'd0, 1});
        vecs.push_back('{enc_b(3'd6), 32'd1, 32'd2, 32'd1, 1});
        vecs.push_back('{enc_b(3'd2), 32'd1, 32'd1, 32'd0, 1});
        vecs.push_back('{{20'hFFFFF, 5'd3, 7'b0110111}, 32'd9, 32'd9, 32'd0, 1});

        // Reset values while reset_n is low.
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset in_ready", in_ready, 1);
        check("reset out", out, 0);
        check("reset64 out_valid", ov64, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i])
            do_op(vecs[i].ins, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

        for (int n = 0; n < 150; n++) begin
            r = $urandom;
            case ($urandom_range(0, 4))
                0: ins = enc_i(r[11:0], r[14:12]);
                1: ins = enc_r(r[15] ? 7'h20 : 7'h00, r[14:12]);
                2: ins = enc_r(7'd1, r[14:12]);
                3: ins = enc_b(r[14:12]);
                default: ins = {r[24:0], 7'b0110111};
            endcase
            a = pick_operand();
            b = pick_operand();
            do_op(ins, a, b, ref32(ins, a, b), ref_lat32(ins, a, b), $sformatf("rnd%0d", n));
        end

        // Back-to-back ADDs: one result per cycle.
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instruction = enc_r(7'd0, 3'd0);
            op_a = $urandom; op_b = $urandom;
            sums[i] = op_a + op_b;
            @(negedge clk);
            check($sformatf("stream%0d valid", i), out_valid, 1);
            check($sformatf("stream%0d sum", i), out, sums[i]);
            $display("[TB] stream%0d out=%h", i, out);
        end
        // Backpressure: result held, new offer refused.
        instruction = enc_r(7'd0, 3'd0); op_a = 32'd1; op_b = 32'd1;
        out_ready = 1'b0;
        #1;
        check("bp in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d valid", i), out_valid, 1);
            check($sformatf("bp%0d out", i), out, sums[3]);
            check($sformatf("bp%0d in_ready", i), in_ready, 0);
            $display("[TB] backpressure%0d out=%h", i, out);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp release valid", out_valid, 0);
        @(negedge clk);
        check("bp decoy dropped", out_valid, 0);

        // Reset during a DIVU iteration discards it.
        in_valid = 1'b1; instruction = enc_r(7'd1, 3'd5); op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("divu busy before reset", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset busy", busy, 0);
        check("midreset in_ready", in_ready, 1);
        check("midreset out", out, 0);
        $display("[TB] reset asserted mid-DIVU");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no stale result", stale, 0);
        do_op(enc_b(3'd6), 32'd1, 32'd2, 32'd1, 1, "BLTU after reset");

        // XLEN=64 instance.
        do_op64(enc_r(7'd1, 3'd3), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFE, 65, "x64 MULHU");
        do_op64(enc_r(7'd1, 3'd0), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'd1, 65, "x64 MUL");
        do_op64(enc_i({6'd0, 6'd63}, 3'd1), 64'd1, 64'd0, 64'h8000_0000_0000_0000, 1, "x64 SLLI");
        do_op64(enc_i({6'b010000, 6'd36}, 3'd5), 64'h8000_0000_0000_0000, 64'd0,
                64'hFFFF_FFFF_F800_0000, 1, "x64 SRAI");
        do_op64(enc_r(7'd1, 3'd4), 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                64'hFFFF_FFFF_FFFF_FFFD, 65, "x64 DIV");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
